branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Execute/memory-boundary stage directly downstream of the 64-bit result zero detector.
- Consumes the zero flag plus ALU N/C/V, holds the architectural NZCV flag register, and resolves B, CBZ, CBNZ and B.cond.
- On a taken branch, drives a one-cycle PC redirect, then squashes wrong-path instructions for a fixed number of cycles.
- Feeds the fetch PC mux and the pipeline-valid chain.

Parameters:
- ADDR_W, 64, width of branch target and redirect PC.
- SQUASH_CYCLES, 2, number of cycles after redirect during which younger in-flight instructions are squashed; legal range 1..7.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- stall  input  1  global pipeline stall; freezes all state.
- ex_valid  input  1  instruction in this stage is valid.
- ex_set_flags  input  1  instruction is a flag-setting op (ADDS/SUBS/ANDS).
- alu_zero  input  1  zero flag from the result zero detector.
- alu_neg  input  1  result bit 63.
- alu_carry  input  1  ALU carry-out.
- alu_ovf  input  1  ALU signed overflow.
- br_kind  input  3  0 none, 1 B, 2 CBZ, 3 CBNZ, 4 B.cond; 5-7 treated as none.
- br_cond  input  4  LEGv8 condition code for B.cond.
- br_target  input  ADDR_W  computed branch target.
- flags  output  4  registered {N,Z,C,V}.
- redirect  output  1  taken-branch PC redirect strobe.
- redirect_pc  output  ADDR_W  target PC, valid while redirect=1.
- squash  output  1  younger instructions currently in flight are wrong-path; kill them.
- busy  output  1  state machine is not in IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - flags=4'b0000, redirect=0, redirect_pc=0, squash=0, busy=0.
  - State returns to IDLE and the squash counter clears, even mid-squash.
- Effective instruction: eff = ex_valid & ~squash & ~stall.
- Flag register: on a clock edge with eff & ex_set_flags, flags <= {alu_neg, alu_zero, alu_carry, alu_ovf}. Otherwise held.
- Condition evaluation:
  - B.cond uses the registered flags, i.e. the result of the most recent older flag-setter. No same-cycle bypass is needed, since a flag-setter is never itself a branch.
  - Codes: EQ 0 Z; NE 1 !Z; HS 2 C; LO 3 !C; MI 4 N; PL 5 !N; VS 6 V; VC 7 !V; HI 8 C&!Z; LS 9 !(C&!Z); GE 10 N==V; LT 11 N!=V; GT 12 !Z&(N==V); LE 13 !(!Z&(N==V)); 14 and 15 always.
- Taken conditions:
  - B: always taken.
  - CBZ: taken when alu_zero=1 (the ALU passes the register through).
  - CBNZ: taken when alu_zero=0.
  - B.cond: taken when the condition code evaluates true.
  - None or undefined kind: never taken.
- State machine (advances only when stall=0):
  - IDLE: if eff and taken, go to REDIRECT.
  - REDIRECT: go to SQUASH and load count=SQUASH_CYCLES-1.
  - SQUASH: if count=0 go to IDLE, else decrement count.
- Output timing:
  - redirect is a registered output: it is 1 for exactly the one cycle the FSM is in REDIRECT, with redirect_pc = the br_target captured at the taken edge.
  - squash=1 in REDIRECT and SQUASH, so the total squash window is SQUASH_CYCLES+1 cycles including the redirect cycle.
  - busy=1 in any non-IDLE state.
  - Latency: taken branch in this stage at edge N gives redirect high in cycle N+1.
- Stall behaviour:
  - stall=1 freezes the state, count, flags and redirect_pc.
  - redirect stays asserted across the stall and is consumed once when stall drops.
- Simultaneous events:
  - While squashing, branches and flag-setters are ignored, including a taken branch arriving while busy.
  - A taken branch in the cycle the FSM returns to IDLE (count=0 edge) is not seen. The next eff instruction is evaluated normally from the following cycle.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: adds outputs br_count[31:0] and taken_count[31:0].
  - br_count increments on every eff with br_kind 1-4.
  - taken_count increments on every taken branch.
  - Both saturate at 32'hFFFF_FFFF, clear on reset, and hold during stall.
- Undefined: neither port nor counters exist; all other behaviour is identical.

Test Plan:
- Reset mid-SQUASH with SQUASH_CYCLES=2 (reset_n low for 1 ns) -> squash, busy and redirect drop to 0 immediately; flags=0000.
- SUBS with alu_zero=1, alu_carry=1, then B.cond EQ with br_target=64'h40 -> flags=0110; redirect=1 for one cycle with redirect_pc=64'h40; squash high for 3 cycles.
- CBZ with alu_zero=0, then CBNZ with alu_zero=0 and br_target=64'h100 -> no redirect on the first; redirect with pc=64'h100 on the second.
- Flags N=1, V=0, then B.cond GE followed by B.cond LT with target 64'h80 -> GE not taken; LT redirects to 64'h80.
- B taken, then a flag-setter ADDS with alu_neg=1 arriving during the squash window -> flags unchanged; the second B in the window does not redirect.
- B taken with stall held 3 cycles at the REDIRECT state -> redirect stays 1 throughout; the squash window restarts counting after stall drops. With BRANCH_STATS_EN defined, br_count=1 and taken_count=1.

Source files
------------

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Holds NZCV, resolves B/CBZ/CBNZ/B.cond, drives a one-cycle
//               PC redirect and then a fixed squash window.
//               Optional macro BRANCH_STATS_EN adds branch/taken counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int ADDR_W        = 64,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic              ex_set_flags,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    input  logic [2:0]        br_kind,
    input  logic [3:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    output logic [3:0]        flags,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              squash,
    output logic              busy
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       br_count,
    output logic [31:0]       taken_count
`endif
);

    localparam logic [2:0] c_squash_load = 3'(SQUASH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_SQUASH   = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_count;

    logic w_eff;
    logic w_cond;
    logic w_taken;
    logic w_is_br;
    logic w_n, w_z, w_c, w_v;

    assign w_eff = ex_valid & ~squash & ~stall;
    assign {w_n, w_z, w_c, w_v} = flags;

    always_comb begin
        w_cond = 1'b0;
        case (br_cond)
            4'd0:    w_cond = w_z;
            4'd1:    w_cond = ~w_z;
            4'd2:    w_cond = w_c;
            4'd3:    w_cond = ~w_c;
            4'd4:    w_cond = w_n;
            4'd5:    w_cond = ~w_n;
            4'd6:    w_cond = w_v;
            4'd7:    w_cond = ~w_v;
            4'd8:    w_cond = w_c & ~w_z;
            4'd9:    w_cond = ~(w_c & ~w_z);
            4'd10:   w_cond = (w_n == w_v);
            4'd11:   w_cond = (w_n != w_v);
            4'd12:   w_cond = ~w_z & (w_n == w_v);
            4'd13:   w_cond = ~(~w_z & (w_n == w_v));
            default: w_cond = 1'b1;
        endcase
    end

    // CBZ/CBNZ test the register passed straight through the ALU.
    always_comb begin
        w_taken = 1'b0;
        w_is_br = 1'b0;
        case (br_kind)
            3'd1: begin w_is_br = 1'b1; w_taken = 1'b1;      end
            3'd2: begin w_is_br = 1'b1; w_taken = alu_zero;  end
            3'd3: begin w_is_br = 1'b1; w_taken = ~alu_zero; end
            3'd4: begin w_is_br = 1'b1; w_taken = w_cond;    end
            default: begin w_is_br = 1'b0; w_taken = 1'b0;   end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_count     <= 3'd0;
            flags       <= 4'b0000;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            squash      <= 1'b0;
            busy        <= 1'b0;
        end else if (!stall) begin
            if (w_eff && ex_set_flags)
                flags <= {alu_neg, alu_zero, alu_carry, alu_ovf};
            case (r_state)
                S_IDLE: begin
                    if (w_eff && w_taken) begin
                        r_state     <= S_REDIRECT;
                        redirect    <= 1'b1;
                        redirect_pc <= br_target;
                        squash      <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                S_REDIRECT: begin
                    r_state  <= S_SQUASH;
                    r_count  <= c_squash_load;
                    redirect <= 1'b0;
                end
                S_SQUASH: begin
                    if (r_count == 3'd0) begin
                        r_state <= S_IDLE;
                        squash  <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        r_count <= r_count - 3'd1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    redirect <= 1'b0;
                    squash   <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_count    <= 32'd0;
            taken_count <= 32'd0;
        end else if (!stall) begin
            if (w_eff && w_is_br && (br_count != 32'hFFFF_FFFF))
                br_count <= br_count + 32'd1;
            if (w_eff && w_taken && (taken_count != 32'hFFFF_FFFF))
                taken_count <= taken_count + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed bench for branch_resolve_unit with a countdown
//               window model and a per-cycle compare process.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int c_sq = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, ex_valid, ex_set_flags;
    logic        alu_zero, alu_neg, alu_carry, alu_ovf;
    logic [2:0]  br_kind;
    logic [3:0]  br_cond;
    logic [63:0] br_target;
    logic [3:0]  flags;
    logic        redirect, squash, busy;
    logic [63:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_count, taken_count;
`endif

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    branch_resolve_unit #(.ADDR_W(64), .SQUASH_CYCLES(c_sq)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .ex_valid(ex_valid),
        .ex_set_flags(ex_set_flags), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .alu_carry(alu_carry), .alu_ovf(alu_ovf), .br_kind(br_kind),
        .br_cond(br_cond), .br_target(br_target), .flags(flags),
        .redirect(redirect), .redirect_pc(redirect_pc), .squash(squash),
        .busy(busy)
`ifdef BRANCH_STATS_EN
        , .br_count(br_count), .taken_count(taken_count)
`endif
    );

    always #5 clk = ~clk;

    // Model: one countdown of remaining wrong-path cycles, c_sq+1 at redirect.
    logic [3:0]  m_flags;
    int          m_win;
    logic [63:0] m_pc;
    longint      m_br, m_tk;

    function automatic bit cond_true(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            0: return z;          1: return !z;
            2: return c;          3: return !c;
            4: return n;          5: return !n;
            6: return v;          7: return !v;
            8: return c && !z;    9: return !(c && !z);
            10: return n == v;    11: return n != v;
            12: return !z && n == v;
            13: return !(!z && n == v);
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit eff, tk, isbr;
        if (!reset_n) begin
            m_flags = 4'b0; m_win = 0; m_pc = 64'h0; m_br = 0; m_tk = 0;
        end else if (!stall) begin
            eff  = ex_valid && (m_win == 0);
            isbr = (br_kind >= 1 && br_kind <= 4);
            tk   = (br_kind == 1) || (br_kind == 2 && alu_zero) ||
                   (br_kind == 3 && !alu_zero) ||
                   (br_kind == 4 && cond_true(br_cond, m_flags));
            if (eff && isbr && m_br < 64'hFFFF_FFFF) m_br++;
            if (eff && tk && m_tk < 64'hFFFF_FFFF) m_tk++;
            if (eff && ex_set_flags) m_flags = {alu_neg, alu_zero, alu_carry, alu_ovf};
            if (m_win > 0) m_win--;
            else if (eff && tk) begin m_win = c_sq + 1; m_pc = br_target; end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && reset_n) begin
            chk("flags", {60'b0, flags}, {60'b0, m_flags});
            chk("redirect", {63'b0, redirect}, {63'b0, (m_win == c_sq + 1)});
            chk("squash", {63'b0, squash}, {63'b0, (m_win > 0)});
            chk("busy", {63'b0, busy}, {63'b0, (m_win > 0)});
            if (m_win == c_sq + 1) chk("redirect_pc", redirect_pc, m_pc);
`ifdef BRANCH_STATS_EN
            chk("br_count", {32'b0, br_count}, m_br);
            chk("taken_count", {32'b0, taken_count}, m_tk);
`endif
        end
    end

    task automatic drive(input logic v, input logic sf, input logic n, input logic z,
                         input logic c, input logic o, input logic [2:0] k,
                         input logic [3:0] cc, input logic [63:0] tgt, input logic st);
        ex_valid = v; ex_set_flags = sf; alu_neg = n; alu_zero = z;
        alu_carry = c; alu_ovf = o; br_kind = k; br_cond = cc;
        br_target = tgt; stall = st;
        @(negedge clk);
    endtask

    task automatic idle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0); endtask
    task automatic setf(input logic n, input logic z, input logic c, input logic o);
        drive(1, 1, n, z, c, o, 0, 0, 64'h0, 0);
    endtask
    task automatic br(input logic [2:0] k, input logic [3:0] cc, input logic z,
                      input logic [63:0] tgt);
        drive(1, 0, 0, z, 0, 0, k, cc, tgt, 0);
    endtask

    task automatic hc(input string name, input logic r, input logic s, input logic [3:0] f);
        chk({name, ".redirect"}, {63'b0, redirect}, {63'b0, r});
        chk({name, ".squash"}, {63'b0, squash}, {63'b0, s});
        chk({name, ".flags"}, {60'b0, flags}, {60'b0, f});
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0);
        idle();
        hc("reset", 0, 0, 4'b0000);
        chk("reset.busy", {63'b0, busy}, 64'h0);
        reset_n = 1'b1;
        started = 1'b1;
        idle();

        // SUBS Z=1 C=1, then B.cond EQ -> 0x40, window of 3 cycles
        setf(0, 1, 1, 0);            hc("subs", 0, 0, 4'b0110);
        br(4, 0, 0, 64'h40);         hc("eq.r", 1, 1, 4'b0110);
        chk("eq.pc", redirect_pc, 64'h40);
        idle();                      hc("eq.s1", 0, 1, 4'b0110);
        idle();                      hc("eq.s2", 0, 1, 4'b0110);
        idle();                      hc("eq.end", 0, 0, 4'b0110);

        // CBZ not taken, CBNZ taken -> 0x100
        br(2, 0, 0, 64'h999);        hc("cbz", 0, 0, 4'b0110);
        br(3, 0, 0, 64'h100);        hc("cbnz", 1, 1, 4'b0110);
        chk("cbnz.pc", redirect_pc, 64'h100);
        idle(); idle(); idle();

        // N=1 V=0: GE not taken, LT taken -> 0x80
        setf(1, 0, 0, 0);            hc("n1", 0, 0, 4'b1000);
        br(4, 10, 0, 64'h555);       hc("ge", 0, 0, 4'b1000);
        br(4, 11, 0, 64'h80);        hc("lt", 1, 1, 4'b1000);
        chk("lt.pc", redirect_pc, 64'h80);
        idle(); idle(); idle();

        // Undefined kind and cond 14 (always)
        br(5, 0, 0, 64'h777);        hc("kind5", 0, 0, 4'b1000);
        br(4, 14, 0, 64'hA0);        hc("al", 1, 1, 4'b1000);
        idle(); idle(); idle();

        // Flag-setter and branches inside the window are ignored
        br(1, 0, 0, 64'h200);        hc("b1", 1, 1, 4'b1000);
        setf(1, 1, 1, 1);            hc("adds_in_win", 0, 1, 4'b1000);
        br(1, 0, 0, 64'h300);        hc("b_in_win", 0, 1, 4'b1000);
        br(1, 0, 0, 64'h340);        hc("b_last", 0, 0, 4'b1000);
        idle();                      hc("after_win", 0, 0, 4'b1000);

        // Async reset mid-SQUASH
        br(1, 0, 0, 64'h500);
        idle();                      hc("pre_rst", 0, 1, 4'b1000);
        #2 reset_n = 1'b0;
        #1;
        hc("rst_mid", 0, 0, 4'b0000);
        chk("rst_mid.busy", {63'b0, busy}, 64'h0);
        reset_n = 1'b1;
        idle();

        // Stall: branch ignored in IDLE, redirect held across stall
        drive(1, 0, 0, 0, 0, 0, 1, 0, 64'h650, 1); hc("stall_idle", 0, 0, 4'b0000);
        br(1, 0, 0, 64'h600);        hc("st.r", 1, 1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 1, 0, 64'h700, 1);
            hc("st.hold", 1, 1, 4'b0000);
            chk("st.pc", redirect_pc, 64'h600);
        end
        idle();                      hc("st.s1", 0, 1, 4'b0000);
        idle();                      hc("st.s2", 0, 1, 4'b0000);
        idle();                      hc("st.end", 0, 0, 4'b0000);
`ifdef BRANCH_STATS_EN
        chk("stats.br", {32'b0, br_count}, 64'd1);
        chk("stats.tk", {32'b0, taken_count}, 64'd1);
`endif
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
